fp_pack: RTL and testbench

- Downstream stage of the mantissa rounding/normalisation block in the 16-input PE datapath.
- Takes the rounded 52-bit mantissa field and the 2-bit exponent increment from that stage, together with the pre-normalisation exponent and the sign.
- Produces the final packed IEEE result for FP64, FP32 or FP16, with overflow/underflow handling.
- Two-stage valid/ready pipeline.

---
 rtl/fp_pkg.sv | 50 +++++
 rtl/fp_pack_fmt.sv | 68 ++++++
 rtl/fp_pack.sv | 125 ++++++++++++
 tb/tb_fp_pack.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared precision encodings, field widths and helpers for the FP pack stage.
// Used by fp_pack and fp_pack_fmt.
package fp_pkg;

  typedef enum logic [1:0] {
    FMT_FP16 = 2'b00,
    FMT_FP32 = 2'b01,
    FMT_FP64 = 2'b10
  } fmt_e;

  localparam int FP64_EW = 11;
  localparam int FP64_MW = 52;
  localparam int FP32_EW = 8;
  localparam int FP32_MW = 23;
  localparam int FP16_EW = 5;
  localparam int FP16_MW = 10;

  localparam int FP64_EMAX = 2047;
  localparam int FP32_EMAX = 255;
  localparam int FP16_EMAX = 31;

  // Encoding 11 is folded onto FP64.
  function automatic fmt_e prec_fmt(input logic [1:0] p);
    fmt_e f;
    unique case (p)
      2'b00:   f = FMT_FP16;
      2'b01:   f = FMT_FP32;
      default: f = FMT_FP64;
    endcase
    return f;
  endfunction

  function automatic logic [1:0] delta_inc(input logic [1:0] d);
    return d[1] ? 2'd2 : {1'b0, d[0]};
  endfunction

  function automatic logic [51:0] mant_mask(
    input fmt_e f,
    input logic [51:0] m
  );
    logic [51:0] r;
    unique case (f)
      FMT_FP16: r = {42'b0, m[9:0]};
      FMT_FP32: r = {29'b0, m[22:0]};
      default:  r = m;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fp_pack_fmt.sv
// Stage-2 classify-and-pack: zero / overflow / underflow / normal
// for FP64, FP32 and FP16, zero-extended to OUT_W.
module fp_pack_fmt
  import fp_pkg::*;
#(
  parameter int EXP_W = 13,
  parameter int OUT_W = 64
) (
  input  logic [1:0]             fmt,
  input  logic                   sign,
  input  logic                   is_zero,
  input  logic signed [EXP_W:0]  e1,
  input  logic [51:0]            mant,
  output logic [OUT_W-1:0]       result,
  output logic                   ovf,
  output logic                   unf
);

  logic signed [EXP_W:0] emax;
  logic [63:0] zero_p;
  logic [63:0] inf_p;
  logic [63:0] norm_p;
  logic [63:0] packed_v;
  logic        e_le0;

  always_comb begin
    emax   = (EXP_W+1)'(FP64_EMAX);
    zero_p = {sign, 63'b0};
    inf_p  = {sign, 11'h7ff, 52'b0};
    norm_p = {sign, e1[10:0], mant};
    unique case (fmt)
      FMT_FP16: begin
        emax   = (EXP_W+1)'(FP16_EMAX);
        zero_p = {48'b0, sign, 15'b0};
        inf_p  = {48'b0, sign, 5'h1f, 10'b0};
        norm_p = {48'b0, sign, e1[4:0], mant[9:0]};
      end
      FMT_FP32: begin
        emax   = (EXP_W+1)'(FP32_EMAX);
        zero_p = {32'b0, sign, 31'b0};
        inf_p  = {32'b0, sign, 8'hff, 23'b0};
        norm_p = {32'b0, sign, e1[7:0], mant[22:0]};
      end
      default: ;
    endcase
  end

  assign e_le0 = e1[EXP_W] || (e1 == '0);

  // Priority: exact zero, then overflow, then flush-to-zero.
  always_comb begin
    ovf      = 1'b0;
    unf      = 1'b0;
    packed_v = norm_p;
    if (is_zero) begin
      packed_v = zero_p;
    end else if (e1 >= emax) begin
      packed_v = inf_p;
      ovf      = 1'b1;
    end else if (e_le0) begin
      packed_v = zero_p;
      unf      = 1'b1;
    end
  end

  assign result = OUT_W'(packed_v);

endmodule

// File: rtl/fp_pack.sv
// Two-stage valid/ready shell packing rounded mantissa into FP64/32/16.
// Optional sticky flags: define FP_PACK_STICKY_FLAGS_EN.
module fp_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 13,
  parameter int OUT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       precision,
  input  logic             sign,
  input  logic             is_zero,
  input  logic [EXP_W-1:0] exp_sum,
  input  logic [1:0]       exp_delta,
  input  logic [51:0]      norm_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             ovf,
  output logic             unf
`ifdef FP_PACK_STICKY_FLAGS_EN
  ,
  input  logic             flag_clr,
  output logic             sticky_ovf,
  output logic             sticky_unf
`endif
);

  logic s1_v;
  logic s2_v;
  logic adv1;
  logic adv2;

  logic                  s1_sign;
  logic                  s1_zero;
  logic [1:0]            s1_fmt;
  logic signed [EXP_W:0] s1_e;
  logic [51:0]           s1_m;

  logic signed [EXP_W:0] e1_n;
  logic [OUT_W-1:0]      f_res;
  logic                  f_ovf;
  logic                  f_unf;

  assign adv2      = !s2_v || out_ready;
  assign adv1      = !s1_v || adv2;
  assign in_ready  = adv1;
  assign out_valid = s2_v;

  assign e1_n = $signed({exp_sum[EXP_W-1], exp_sum})
              + $signed({{(EXP_W-1){1'b0}}, delta_inc(exp_delta)});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_sign <= 1'b0;
      s1_zero <= 1'b0;
      s1_fmt  <= 2'b00;
      s1_e    <= '0;
      s1_m    <= '0;
    end else if (adv1) begin
      s1_v <= in_valid;
      if (in_valid) begin
        s1_sign <= sign;
        s1_zero <= is_zero;
        s1_fmt  <= prec_fmt(precision);
        s1_e    <= e1_n;
        s1_m    <= mant_mask(prec_fmt(precision), norm_in);
      end
    end
  end

  fp_pack_fmt #(
    .EXP_W (EXP_W),
    .OUT_W (OUT_W)
  ) u_fmt (
    .fmt     (s1_fmt),
    .sign    (s1_sign),
    .is_zero (s1_zero),
    .e1      (s1_e),
    .mant    (s1_m),
    .result  (f_res),
    .ovf     (f_ovf),
    .unf     (f_unf)
  );

  // Output regs hold while stalled so downstream sees a stable value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v   <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (adv2) begin
      s2_v <= s1_v;
      if (s1_v) begin
        result <= f_res;
        ovf    <= f_ovf;
        unf    <= f_unf;
      end
    end
  end

`ifdef FP_PACK_STICKY_FLAGS_EN
  logic xfer;
  assign xfer = out_valid && out_ready;

  // Set beats clear when both land in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_ovf <= 1'b0;
      sticky_unf <= 1'b0;
    end else begin
      if (xfer && ovf)   sticky_ovf <= 1'b1;
      else if (flag_clr) sticky_ovf <= 1'b0;
      if (xfer && unf)   sticky_unf <= 1'b1;
      else if (flag_clr) sticky_unf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fp_pack.sv
// Self-checking bench for fp_pack: directed table, random stream with
// a scoreboard model, stall burst and mid-flight reset.
module tb_fp_pack;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  precision;
  logic        sign;
  logic        is_zero;
  logic [12:0] exp_sum;
  logic [1:0]  exp_delta;
  logic [51:0] norm_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        ovf;
  logic        unf;
`ifdef FP_PACK_STICKY_FLAGS_EN
  logic        flag_clr = 1'b0;
  logic        sticky_ovf;
  logic        sticky_unf;
`endif

  always #5 clk = ~clk;

  fp_pack #(.EXP_W(13), .OUT_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .precision (precision),
    .sign      (sign),
    .is_zero   (is_zero),
    .exp_sum   (exp_sum),
    .exp_delta (exp_delta),
    .norm_in   (norm_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .unf       (unf)
`ifdef FP_PACK_STICKY_FLAGS_EN
    ,
    .flag_clr   (flag_clr),
    .sticky_ovf (sticky_ovf),
    .sticky_unf (sticky_unf)
`endif
  );

  typedef struct {
    logic [1:0]         prec;
    logic               sign;
    logic               zero;
    logic signed [12:0] es;
    logic [1:0]         d;
    logic [51:0]        m;
    logic [63:0]        r;
    logic               o;
    logic               u;
  } vec_t;

  typedef struct {
    logic [63:0] r;
    logic        o;
    logic        u;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;

  function automatic void chk(input string nm, input logic [63:0] act,
                              input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endfunction

  // Reference: IEEE field arithmetic from the format rules.
  function automatic exp_t model(input logic [1:0] p, input logic s,
                                 input logic z, input int es,
                                 input logic [1:0] d,
                                 input logic [51:0] m);
    exp_t x;
    int w, mw, emax, e;
    logic [63:0] sb, mask;
    if (p == 2'b00) begin
      w = 16; mw = 10; emax = 31;
    end else if (p == 2'b01) begin
      w = 32; mw = 23; emax = 255;
    end else begin
      w = 64; mw = 52; emax = 2047;
    end
    e = es + ((d == 2'b00) ? 0 : (d == 2'b01) ? 1 : 2);
    sb = 64'(s) << (w - 1);
    mask = (64'd1 << mw) - 64'd1;
    x.o = 1'b0;
    x.u = 1'b0;
    if (z) begin
      x.r = sb;
    end else if (e >= emax) begin
      x.r = sb | (64'(emax) << mw);
      x.o = 1'b1;
    end else if (e <= 0) begin
      x.r = sb;
      x.u = 1'b1;
    end else begin
      x.r = sb | (64'(e) << mw) | ({12'b0, m} & mask);
    end
    return x;
  endfunction

  // Scoreboard: push on accept, compare on emit.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_extra: got %h want none", result);
        end else begin
          mon_e = q.pop_front();
          chk("sb_result", result, mon_e.r);
          chk("sb_ovf", 64'(ovf), 64'(mon_e.o));
          chk("sb_unf", 64'(unf), 64'(mon_e.u));
        end
      end
      if (in_valid && in_ready)
        q.push_back(model(precision, sign, is_zero,
                          int'($signed(exp_sum)), exp_delta, norm_in));
    end
  end

  task automatic send(input vec_t v, input bit rnd);
    int n;
    precision = v.prec;
    sign      = v.sign;
    is_zero   = v.zero;
    exp_sum   = v.es;
    exp_delta = v.d;
    norm_in   = v.m;
    in_valid  = 1'b1;
    if (rnd) out_ready = ($urandom_range(3) != 0);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(posedge clk); #1;
      if (rnd) out_ready = ($urandom_range(3) != 0);
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_q", 64'(q.size()), 64'd0);
  endtask

  vec_t tbl[10];
  vec_t v;
  logic [63:0] r0;
  int   n0;
  int   emax;

  initial begin
    tbl[0] = '{2'b10, 1'b0, 1'b0, 13'sd1023, 2'b01, 52'h0,
               64'h4000000000000000, 1'b0, 1'b0};
    tbl[1] = '{2'b01, 1'b0, 1'b0, 13'sd254, 2'b01, 52'h0,
               64'h000000007F800000, 1'b1, 1'b0};
    tbl[2] = '{2'b00, 1'b1, 1'b0, -13'sd3, 2'b00, 52'h155,
               64'h0000000000008000, 1'b0, 1'b1};
    tbl[3] = '{2'b10, 1'b1, 1'b1, 13'sd3000, 2'b00, 52'h0,
               64'h8000000000000000, 1'b0, 1'b0};
    tbl[4] = '{2'b01, 1'b0, 1'b0, 13'sd126, 2'b01, 52'hFFFFFFFFFFFFF,
               64'h000000003FFFFFFF, 1'b0, 1'b0};
    tbl[5] = '{2'b00, 1'b0, 1'b0, 13'sd30, 2'b10, 52'h3FF,
               64'h0000000000007C00, 1'b1, 1'b0};
    tbl[6] = '{2'b00, 1'b1, 1'b0, 13'sd0, 2'b01, 52'hFFFFF,
               64'h00000000000087FF, 1'b0, 1'b0};
    tbl[7] = '{2'b11, 1'b0, 1'b0, -13'sd1, 2'b01, 52'h5,
               64'h0000000000000000, 1'b0, 1'b1};
    tbl[8] = '{2'b11, 1'b0, 1'b0, 13'sd2045, 2'b11, 52'h1,
               64'h7FF0000000000000, 1'b1, 1'b0};
    tbl[9] = '{2'b10, 1'b0, 1'b0, 13'sd2046, 2'b00, 52'h123456789ABCD,
               64'h7FE123456789ABCD, 1'b0, 1'b0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    precision = 2'b00;
    sign = 1'b0;
    is_zero = 1'b0;
    exp_sum = '0;
    exp_delta = 2'b00;
    norm_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_unf", 64'(unf), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed table, one item at a time, two-cycle latency.
    for (int i = 0; i < 10; i++) begin
      out_ready = 1'b1;
      send(tbl[i], 1'b0);
      chk($sformatf("tbl%0d_early", i), 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("tbl%0d_result", i), result, tbl[i].r);
      chk($sformatf("tbl%0d_ovf", i), 64'(ovf), 64'(tbl[i].o));
      chk($sformatf("tbl%0d_unf", i), 64'(unf), 64'(tbl[i].u));
    end
    drain();

    // Random stream with random back-pressure.
    for (int i = 0; i < 400; i++) begin
      v.prec = 2'($urandom_range(3));
      v.sign = 1'($urandom);
      v.zero = ($urandom_range(7) == 0);
      emax = (v.prec == 2'b00) ? 31 : (v.prec == 2'b01) ? 255 : 2047;
      if ($urandom_range(15) == 0)
        v.es = 13'($urandom);
      else
        v.es = 13'(int'($urandom_range(emax + 6)) - 4);
      v.d = 2'($urandom_range(3));
      v.m = {20'($urandom), 32'($urandom)};
      send(v, 1'b1);
    end
    drain();

    // Stall burst: two stages fill, in_ready drops, output holds.
    n0 = n_out;
    out_ready = 1'b0;
    send(tbl[0], 1'b0);
    send(tbl[4], 1'b0);
    precision = tbl[6].prec;
    sign = tbl[6].sign;
    is_zero = tbl[6].zero;
    exp_sum = tbl[6].es;
    exp_delta = tbl[6].d;
    norm_in = tbl[6].m;
    in_valid = 1'b1;
    @(negedge clk);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_head", result, tbl[0].r);
    r0 = result;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_hold", result, r0);
      chk("stall_valid", 64'(out_valid), 64'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(tbl[6], 1'b0);
    send(tbl[9], 1'b0);
    drain();
    chk("burst_count", 64'(n_out - n0), 64'd4);

    // Reset with two items in flight.
    out_ready = 1'b0;
    send(tbl[1], 1'b0);
    send(tbl[2], 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("postrst_idle", 64'(out_valid), 64'd0);
    send(tbl[0], 1'b0);
    chk("postrst_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("postrst_valid", 64'(out_valid), 64'd1);
    chk("postrst_result", result, tbl[0].r);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
